// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial word comparator.
// State encoding, pair result bundle and result constants.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t RES_EQ   = 3'b010;
  localparam cmp_res_t RES_NONE = 3'b000;

endpackage

// File: rtl/serial_word_comparator_if.sv
// Beat input and result output handshake bundle.
// Parity outputs exist only when PARITY_CHK_EN is defined.
interface serial_word_comparator_if;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] a_pair;
  logic [1:0] b_pair;
  logic       out_valid;
  logic       out_ready;
  logic       gt;
  logic       eq;
  logic       lt;
  logic       busy;
`ifdef PARITY_CHK_EN
  logic       par_a;
  logic       par_b;
`endif

  modport slave (
    input  in_valid,
    input  a_pair,
    input  b_pair,
    input  out_ready,
    output in_ready,
    output out_valid,
    output gt,
    output eq,
    output lt,
`ifdef PARITY_CHK_EN
    output par_a,
    output par_b,
`endif
    output busy
  );

  modport master (
    output in_valid,
    output a_pair,
    output b_pair,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  gt,
    input  eq,
    input  lt,
`ifdef PARITY_CHK_EN
    input  par_a,
    input  par_b,
`endif
    input  busy
  );

endinterface

// File: rtl/serial_word_comparator_pair_cmp.sv
// Combinational 2-bit magnitude compare.
// Produces a one-hot {gt, eq, lt} result.
module pair_cmp
  import serial_cmp_pkg::*;
(
  input  logic [1:0] a_pair,
  input  logic [1:0] b_pair,
  output cmp_res_t   res
);

  always_comb begin
    res = RES_NONE;
    unique case (1'b1)
      (a_pair > b_pair):  res = 3'b100;
      (a_pair == b_pair): res = RES_EQ;
      default:            res = 3'b001;
    endcase
  end

endmodule

// File: rtl/serial_word_comparator.sv
// MSB-first serial word compare with sticky result and valid/ready output.
// Define PARITY_CHK_EN to add per-operand word parity outputs.
module serial_word_comparator
  import serial_cmp_pkg::*;
#(
  parameter int N_PAIRS = 4
) (
  input logic clk,
  input logic rst_n,
  serial_word_comparator_if.slave bus
);

  localparam int CW = $clog2(N_PAIRS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_PAIRS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  cmp_res_t      acc;
  cmp_res_t      pr;
  logic          take;
  logic          done;

  pair_cmp u_pair (
    .a_pair(bus.a_pair),
    .b_pair(bus.b_pair),
    .res   (pr)
  );

  assign done          = (state == DONE);
  assign take          = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = !done;
  assign bus.busy      = (state == SHIFT);
  assign bus.out_valid = done;
  assign bus.gt        = done & acc.gt;
  assign bus.eq        = done & acc.eq;
  assign bus.lt        = done & acc.lt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (take)
          state_nxt = (N_PAIRS == 1) ? DONE : SHIFT;
      SHIFT:
        if (take && cnt == LAST)
          state_nxt = DONE;
      DONE:
        if (bus.out_ready)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // Once a pair decides gt/lt, later pairs are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= RES_NONE;
    end else begin
      state <= state_nxt;
      if (done) begin
        if (bus.out_ready) begin
          cnt <= '0;
          acc <= RES_NONE;
        end
      end else if (take) begin
        if (state == IDLE) begin
          cnt <= CW'(1);
          acc <= pr;
        end else begin
          cnt <= cnt + CW'(1);
          if (acc.eq)
            acc <= pr;
        end
      end
    end
  end

`ifdef PARITY_CHK_EN
  logic par_a_q;
  logic par_b_q;

  assign bus.par_a = done & par_a_q;
  assign bus.par_b = done & par_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_a_q <= 1'b0;
      par_b_q <= 1'b0;
    end else if (done) begin
      if (bus.out_ready) begin
        par_a_q <= 1'b0;
        par_b_q <= 1'b0;
      end
    end else if (take) begin
      par_a_q <= (state == IDLE ? 1'b0 : par_a_q) ^ (^bus.a_pair);
      par_b_q <= (state == IDLE ? 1'b0 : par_b_q) ^ (^bus.b_pair);
    end
  end
`endif

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed and randomized bench for serial_word_comparator.
// Expected results come from whole-word integer compare and XOR parity.
module tb_serial_word_comparator;

  localparam int NP = 4;
  localparam int W  = 2 * NP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_word_comparator_if bus ();

  serial_word_comparator #(.N_PAIRS(NP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] a, input logic [1:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a_pair   = a;
    bus.b_pair   = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept_in_time", 32'(n < 50), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall_after, input int stall_len);
    for (int k = 0; k < NP; k++) begin
      int i = NP - 1 - k;
      chk("no_early_valid", bus.out_valid, 0);
      if (k > 0) chk("busy_mid_word", bus.busy, 1);
      beat(a[2*i +: 2], b[2*i +: 2]);
      if (k == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_busy", bus.busy, 1);
          chk("stall_no_valid", bus.out_valid, 0);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a,
                              input logic [W-1:0] b);
    chk({tag, "_out_valid"}, bus.out_valid, 1);
    chk({tag, "_gt"}, bus.gt, 32'(a > b));
    chk({tag, "_eq"}, bus.eq, 32'(a == b));
    chk({tag, "_lt"}, bus.lt, 32'(a < b));
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_busy"}, bus.busy, 0);
`ifdef PARITY_CHK_EN
    chk({tag, "_par_a"}, bus.par_a, 32'(^a));
    chk({tag, "_par_b"}, bus.par_b, 32'(^b));
`endif
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_valid"}, bus.out_valid, 0);
    chk({tag, "_idle_ready"}, bus.in_ready, 1);
    chk({tag, "_idle_flags"}, {bus.gt, bus.eq, bus.lt}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, a2, b2;
    bus.in_valid  = 1'b0;
    bus.a_pair    = 2'b00;
    bus.b_pair    = 2'b00;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_flags", {bus.gt, bus.eq, bus.lt}, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_word(8'hB4, 8'hB3, -1, 0);
    check_result("b4_b3", 8'hB4, 8'hB3);
    release_result("b4_b3");

    run_word(8'h5A, 8'h5A, -1, 0);
    check_result("eq_5a", 8'h5A, 8'h5A);
    release_result("eq_5a");
    chk("eq_5a_idle_busy", bus.busy, 0);

    run_word(8'h3F, 8'h40, -1, 0);
    check_result("sticky_lt", 8'h3F, 8'h40);
    release_result("sticky_lt");

    run_word(8'hB4, 8'hB3, 1, 3);
    check_result("stall", 8'hB4, 8'hB3);
    release_result("stall");

    a  = 8'(($urandom));
    b  = 8'(($urandom));
    a2 = 8'(($urandom));
    b2 = 8'(($urandom));
    bus.out_ready = 1'b0;
    run_word(a, b, -1, 0);
    bus.in_valid = 1'b1;
    bus.a_pair   = a2[W-1 -: 2];
    bus.b_pair   = b2[W-1 -: 2];
    for (int c = 0; c < 5; c++) begin
      check_result("bp_hold", a, b);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", bus.in_ready, 1);
    chk("bp_idle_valid", bus.out_valid, 0);
    chk("bp_idle_busy", bus.busy, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_pending_taken", bus.busy, 1);
    for (int k = 1; k < NP; k++) begin
      int i = NP - 1 - k;
      beat(a2[2*i +: 2], b2[2*i +: 2]);
    end
    check_result("bp_next", a2, b2);
    release_result("bp_next");

    beat(2'b11, 2'b00);
    beat(2'b01, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_ready", bus.in_ready, 1);
    chk("async_rst_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(8'h77, 8'h77, -1, 0);
    check_result("post_rst", 8'h77, 8'h77);
    release_result("post_rst");

    for (int t = 0; t < 30; t++) begin
      int hold;
      a = 8'($urandom);
      b = ($urandom_range(3) == 0) ? a : 8'($urandom);
      if ($urandom_range(1) == 1) b[1:0] = a[1:0] ^ 2'b01;
      hold = $urandom_range(3);
      bus.out_ready = (hold == 0);
      run_word(a, b, $urandom_range(NP - 2), $urandom_range(2));
      for (int c = 0; c < hold; c++) begin
        check_result("rand_hold", a, b);
        @(negedge clk);
      end
      check_result("rand", a, b);
      release_result("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
